// File: rtl/csr_access_ctrl_pkg.sv
// Shared encodings for the CSR access sequencer and the CSR unit it drives.
package csr_access_ctrl_pkg;

  typedef enum logic [2:0] {
    CSR_OP_NONE  = 3'd0,
    CSR_OP_RW    = 3'd1,
    CSR_OP_RS    = 3'd2,
    CSR_OP_RC    = 3'd3,
    CSR_OP_ECALL = 3'd4,
    CSR_OP_MRET  = 3'd5
  } csr_op_e;

  // Must match the CSR unit's control decode.
  typedef enum logic [2:0] {
    CTL_NOP   = 3'd0,
    CTL_CSRW  = 3'd1,
    CTL_ECALL = 3'd2,
    CTL_MRET  = 3'd3
  } csr_ctl_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic csr_addr_legal(input logic [11:0] a);
    return (a == CSR_MSTATUS) || (a == CSR_MTVEC) || (a == CSR_MEPC) || (a == CSR_MCAUSE);
  endfunction

  function automatic logic op_is_rmw(input csr_op_e op);
    return (op == CSR_OP_RW) || (op == CSR_OP_RS) || (op == CSR_OP_RC);
  endfunction

endpackage

// File: rtl/csr_access_ctrl_wdata.sv
// New-value and write-needed computation for one CSR-class instruction.
module csr_wdata_calc
  import csr_access_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  input  logic            i_src_zero,
  input  logic            i_addr_legal,
  output logic [XLEN-1:0] o_new,
  output logic            o_wr
);

  always_comb begin
    o_new = '0;
    o_wr  = 1'b0;
    case (i_op)
      CSR_OP_RW: begin
        o_new = i_src;
        o_wr  = i_addr_legal;
      end
      // Set/clear with a zero source is a pure read: no side effects.
      CSR_OP_RS: begin
        o_new = i_old | i_src;
        o_wr  = i_addr_legal & ~i_src_zero;
      end
      CSR_OP_RC: begin
        o_new = i_old & ~i_src;
        o_wr  = i_addr_legal & ~i_src_zero;
      end
      CSR_OP_ECALL: o_wr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Read-modify-write sequencer between decode/execute and the CSR unit.
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_src_zero,
  input  logic [XLEN-1:0] req_pc,
  output logic [11:0]     csr_addr,
  output logic [2:0]      csr_ctl,
  output logic            csr_wen,
  output logic            csr_commit,
  output logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_pc,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] csr_upc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_redirect,
  output logic [XLEN-1:0] rsp_npc,
  output logic            rsp_illegal
);

  state_e          r_state;
  csr_op_e         r_op;
  logic [11:0]     r_addr;
  logic [XLEN-1:0] r_src, r_pc, r_old, r_upc;
  logic            r_src_zero;
  logic [11:0]     r_csr_addr;
  logic [2:0]      r_csr_ctl;
  logic            r_csr_wen;
  logic [XLEN-1:0] r_csr_wdata, r_csr_pc;
  logic            r_rsp_valid, r_rsp_redirect, r_rsp_illegal;
  logic [XLEN-1:0] r_rsp_rdata, r_rsp_npc;

  logic [XLEN-1:0] w_new;
  logic            w_wr, w_legal, w_rmw, w_trap;

  assign w_legal = csr_addr_legal(r_addr);
  assign w_rmw   = op_is_rmw(r_op);
  assign w_trap  = (r_op == CSR_OP_ECALL) || (r_op == CSR_OP_MRET);

  csr_wdata_calc #(.XLEN(XLEN)) u_wdata_calc (
    .i_op         (r_op),
    .i_old        (csr_rdata),
    .i_src        (r_src),
    .i_src_zero   (r_src_zero),
    .i_addr_legal (w_legal),
    .o_new        (w_new),
    .o_wr         (w_wr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_op           <= CSR_OP_NONE;
      r_addr         <= '0;
      r_src          <= '0;
      r_src_zero     <= 1'b0;
      r_pc           <= '0;
      r_old          <= '0;
      r_upc          <= '0;
      r_csr_addr     <= '0;
      r_csr_ctl      <= CTL_NOP;
      r_csr_wen      <= 1'b0;
      r_csr_wdata    <= '0;
      r_csr_pc       <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
      r_rsp_redirect <= 1'b0;
      r_rsp_npc      <= '0;
      r_rsp_illegal  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_op       <= csr_op_e'(req_op);
          r_addr     <= req_addr;
          r_src      <= req_src;
          r_src_zero <= req_src_zero;
          r_pc       <= req_pc;
          r_csr_addr <= req_addr;
          // Trap ops present their ctl during READ so csr_upc is valid there.
          case (req_op)
            CSR_OP_ECALL: r_csr_ctl <= CTL_ECALL;
            CSR_OP_MRET:  r_csr_ctl <= CTL_MRET;
            default:      r_csr_ctl <= CTL_NOP;
          endcase
          r_state <= ST_READ;
        end
        ST_READ: begin
          r_old       <= csr_rdata;
          r_upc       <= w_trap ? csr_upc : '0;
          r_csr_wen   <= w_wr;
          r_csr_wdata <= w_new;
          r_csr_pc    <= (r_op == CSR_OP_ECALL) ? r_pc : '0;
          if (!w_wr)                    r_csr_ctl <= CTL_NOP;
          else if (r_op == CSR_OP_ECALL) r_csr_ctl <= CTL_ECALL;
          else                          r_csr_ctl <= CTL_CSRW;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_csr_addr     <= '0;
          r_csr_ctl      <= CTL_NOP;
          r_csr_wen      <= 1'b0;
          r_csr_wdata    <= '0;
          r_csr_pc       <= '0;
          r_rsp_valid    <= 1'b1;
          r_rsp_rdata    <= (w_rmw && w_legal) ? r_old : '0;
          r_rsp_redirect <= w_trap;
          r_rsp_npc      <= w_trap ? r_upc : '0;
          r_rsp_illegal  <= w_rmw && !w_legal;
          r_state        <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) begin
          r_rsp_valid    <= 1'b0;
          r_rsp_rdata    <= '0;
          r_rsp_redirect <= 1'b0;
          r_rsp_npc      <= '0;
          r_rsp_illegal  <= 1'b0;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // rst masks every output immediately, so a write in flight never commits.
  assign req_ready    = (r_state == ST_IDLE) && !rst;
  assign csr_wen      = r_csr_wen && !rst;
  assign csr_commit   = r_csr_wen && !rst;
  assign csr_addr     = rst ? '0 : r_csr_addr;
  assign csr_ctl      = rst ? CTL_NOP : r_csr_ctl;
  assign csr_wdata    = rst ? '0 : r_csr_wdata;
  assign csr_pc       = rst ? '0 : r_csr_pc;
  assign rsp_valid    = r_rsp_valid && !rst;
  assign rsp_rdata    = rst ? '0 : r_rsp_rdata;
  assign rsp_redirect = r_rsp_redirect && !rst;
  assign rsp_npc      = rst ? '0 : r_rsp_npc;
  assign rsp_illegal  = r_rsp_illegal && !rst;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench: CSR-unit environment, directed table, corner sequences, random ops vs model.
module tb_csr_access_ctrl;
  import csr_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_src = '0, req_pc = '0;
  logic        req_src_zero = 1'b0;
  logic [11:0] csr_addr;
  logic [2:0]  csr_ctl;
  logic        csr_wen, csr_commit;
  logic [31:0] csr_wdata, csr_pc, csr_rdata, csr_upc;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_redirect, rsp_illegal;
  logic [31:0] rsp_rdata, rsp_npc;

  always #5 clk = ~clk;

  csr_access_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_src(req_src), .req_src_zero(req_src_zero), .req_pc(req_pc),
    .csr_addr(csr_addr), .csr_ctl(csr_ctl), .csr_wen(csr_wen), .csr_commit(csr_commit),
    .csr_wdata(csr_wdata), .csr_pc(csr_pc), .csr_rdata(csr_rdata), .csr_upc(csr_upc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_redirect(rsp_redirect), .rsp_npc(rsp_npc), .rsp_illegal(rsp_illegal)
  );

  // CSR unit environment: mstatus reads as a constant 0x1800.
  logic [31:0] env_mtvec = '0, env_mepc = '0, env_mcause = '0;
  always_comb begin
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = 32'h1800;
      CSR_MTVEC:   csr_rdata = env_mtvec;
      CSR_MEPC:    csr_rdata = env_mepc;
      CSR_MCAUSE:  csr_rdata = env_mcause;
      default:     csr_rdata = '0;
    endcase
    csr_upc = (csr_ctl == CTL_ECALL) ? env_mtvec : (csr_ctl == CTL_MRET) ? env_mepc : '0;
  end
  always @(posedge clk) begin
    if (csr_wen && csr_commit) begin
      if (csr_ctl == CTL_CSRW) begin
        if (csr_addr == CSR_MTVEC) env_mtvec <= csr_wdata;
        if (csr_addr == CSR_MEPC)  env_mepc  <= csr_wdata;
        if (csr_addr == CSR_MCAUSE) env_mcause <= csr_wdata;
      end else if (csr_ctl == CTL_ECALL) begin
        env_mepc   <= csr_pc;
        env_mcause <= 32'hB;
      end
    end
  end

  typedef struct packed {
    logic        wen;
    logic [2:0]  ctl;
    logic [31:0] wdata, pc, rdata;
    logic        redir;
    logic [31:0] npc;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic        timeout, unstable, redir, ill;
    logic [3:0]  wen_cnt, wen_cyc, lat;
    logic [11:0] raddr;
    logic [2:0]  ctl;
    logic [31:0] wdata, pc, rdata, npc;
  } obs_t;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        sz;
    logic [31:0] pc;
    exp_t        e;
  } vec_t;

  int unsigned n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: architectural CSR state and the per-op rules.
  logic [31:0] m_mtvec = '0, m_mepc = '0, m_mcause = '0;

  task automatic model_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                          input logic sz, input logic [31:0] pc, output exp_t e);
    logic [31:0] old, nv;
    logic rw, legal;
    rw    = op inside {CSR_OP_RW, CSR_OP_RS, CSR_OP_RC};
    legal = addr inside {CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE};
    old   = (addr == CSR_MSTATUS) ? 32'h1800 : (addr == CSR_MTVEC) ? m_mtvec :
            (addr == CSR_MEPC) ? m_mepc : (addr == CSR_MCAUSE) ? m_mcause : 32'h0;
    e = '0;
    if (rw && legal) begin
      e.rdata = old;
      nv = (op == CSR_OP_RW) ? src : (op == CSR_OP_RS) ? (old | src) : (old & ~src);
      if (op == CSR_OP_RW || !sz) begin
        e.wen = 1'b1; e.ctl = CTL_CSRW; e.wdata = nv;
        if (addr == CSR_MTVEC) m_mtvec = nv;
        if (addr == CSR_MEPC) m_mepc = nv;
        if (addr == CSR_MCAUSE) m_mcause = nv;
      end
    end else if (rw) begin
      e.ill = 1'b1;
    end else if (op == CSR_OP_ECALL) begin
      e.wen = 1'b1; e.ctl = CTL_ECALL; e.pc = pc; e.redir = 1'b1; e.npc = m_mtvec;
      m_mepc = pc; m_mcause = 32'hB;
    end else if (op == CSR_OP_MRET) begin
      e.redir = 1'b1; e.npc = m_mepc;
    end
  endtask

  // Pending request presented while the response is back-pressured.
  logic        bp_en = 1'b0;
  logic [2:0]  bp_op = '0;
  logic [11:0] bp_addr = '0;

  task automatic run_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                        input logic sz, input logic [31:0] pc, input int unsigned stall, output obs_t o);
    int unsigned k;
    o = '0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src; req_src_zero = sz; req_pc = pc;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    if (!req_ready) begin o.timeout = 1'b1; req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0;
    o.raddr = csr_addr;
    k = 1;
    while (!rsp_valid && k < 12) begin
      if (csr_wen) begin
        o.wen_cnt++; o.wen_cyc = 4'(k); o.ctl = csr_ctl; o.wdata = csr_wdata; o.pc = csr_pc;
      end
      @(negedge clk); k++;
    end
    if (!rsp_valid) begin o.timeout = 1'b1; return; end
    o.lat = 4'(k); o.rdata = rsp_rdata; o.redir = rsp_redirect; o.npc = rsp_npc; o.ill = rsp_illegal;
    if (bp_en) begin req_valid = 1'b1; req_op = bp_op; req_addr = bp_addr; end
    for (int i = 0; i < int'(stall); i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== o.rdata || rsp_redirect !== o.redir || rsp_npc !== o.npc ||
          rsp_illegal !== o.ill || req_ready || csr_wen) o.unstable = 1'b1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic verify(input string tag, input logic [11:0] addr, input int unsigned stall,
                        input exp_t e, input obs_t o);
    check({tag, ".timeout"}, 32'(o.timeout), 32'h0);
    check({tag, ".latency"}, 32'(o.lat), 32'd3);
    check({tag, ".read_addr"}, 32'(o.raddr), 32'(addr));
    check({tag, ".wen_count"}, 32'(o.wen_cnt), 32'(e.wen));
    if (e.wen) begin
      check({tag, ".wen_cycle"}, 32'(o.wen_cyc), 32'd2);
      check({tag, ".ctl"}, 32'(o.ctl), 32'(e.ctl));
      if (e.ctl == CTL_CSRW) check({tag, ".wdata"}, o.wdata, e.wdata);
      else                   check({tag, ".mepc_pc"}, o.pc, e.pc);
    end
    check({tag, ".rdata"}, o.rdata, e.rdata);
    check({tag, ".redirect"}, 32'(o.redir), 32'(e.redir));
    check({tag, ".npc"}, o.npc, e.npc);
    check({tag, ".illegal"}, 32'(o.ill), 32'(e.ill));
    if (stall > 0) check({tag, ".stable"}, 32'(o.unstable), 32'h0);
  endtask

  function automatic vec_t V(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                             input logic sz, input logic [31:0] pc, input logic wen, input logic [2:0] ctl,
                             input logic [31:0] wdata, input logic [31:0] rdata, input logic redir,
                             input logic [31:0] npc, input logic ill);
    vec_t v;
    v.op = op; v.addr = addr; v.src = src; v.sz = sz; v.pc = pc;
    v.e = '{wen: wen, ctl: ctl, wdata: wdata, pc: pc, rdata: rdata, redir: redir, npc: npc, ill: ill};
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [10];
    obs_t  o;
    exp_t  e;
    logic [2:0]  ops  [5];
    logic [11:0] adrs [5];
    int unsigned k;

    tbl[0] = V(CSR_OP_RW,    12'h305, 32'h80000100, 0, 32'h0,        1, CTL_CSRW,  32'h80000100, 32'h0,        0, 32'h0,        0);
    tbl[1] = V(CSR_OP_RS,    12'h300, 32'h8,        0, 32'h0,        1, CTL_CSRW,  32'h1808,     32'h1800,     0, 32'h0,        0);
    tbl[2] = V(CSR_OP_RW,    12'h341, 32'h1234,     0, 32'h0,        1, CTL_CSRW,  32'h1234,     32'h0,        0, 32'h0,        0);
    tbl[3] = V(CSR_OP_RC,    12'h341, 32'h0,        1, 32'h0,        0, CTL_NOP,   32'h0,        32'h1234,     0, 32'h0,        0);
    tbl[4] = V(CSR_OP_ECALL, 12'h000, 32'h0,        0, 32'h80000040, 1, CTL_ECALL, 32'h0,        32'h0,        1, 32'h80000100, 0);
    tbl[5] = V(CSR_OP_RS,    12'h342, 32'h0,        1, 32'h0,        0, CTL_NOP,   32'h0,        32'hB,        0, 32'h0,        0);
    tbl[6] = V(CSR_OP_MRET,  12'h000, 32'h0,        0, 32'h0,        0, CTL_NOP,   32'h0,        32'h0,        1, 32'h80000040, 0);
    tbl[7] = V(CSR_OP_RC,    12'h300, 32'h800,      0, 32'h0,        1, CTL_CSRW,  32'h1000,     32'h1800,     0, 32'h0,        0);
    tbl[8] = V(CSR_OP_RW,    12'h7C0, 32'h5,        0, 32'h0,        0, CTL_NOP,   32'h0,        32'h0,        0, 32'h0,        1);
    tbl[9] = V(CSR_OP_RS,    12'h305, 32'h3,        0, 32'h0,        1, CTL_CSRW,  32'h80000103, 32'h80000100, 0, 32'h0,        0);

    // Reset state
    @(negedge clk);
    check("reset.req_ready", 32'(req_ready), 32'h0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset.csr_wen", 32'(csr_wen), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle.req_ready", 32'(req_ready), 32'h1);
    check("idle.csr_ctl", 32'(csr_ctl), 32'h0);

    foreach (tbl[i]) begin
      model_op(tbl[i].op, tbl[i].addr, tbl[i].src, tbl[i].sz, tbl[i].pc, e);
      run_op(tbl[i].op, tbl[i].addr, tbl[i].src, tbl[i].sz, tbl[i].pc, 0, o);
      verify($sformatf("vec%0d", i), tbl[i].addr, 0, tbl[i].e, o);
    end

    // Back-pressure with a competing request held valid during RESP.
    bp_en = 1'b1; bp_op = CSR_OP_RW; bp_addr = CSR_MCAUSE;
    model_op(CSR_OP_RS, CSR_MEPC, 32'h0, 1'b1, 32'h0, e);
    run_op(CSR_OP_RS, CSR_MEPC, 32'h0, 1'b1, 32'h0, 5, o);
    verify("bp_first", CSR_MEPC, 5, e, o);
    bp_en = 1'b0;
    model_op(CSR_OP_RW, CSR_MCAUSE, 32'h55, 1'b0, 32'h0, e);
    run_op(CSR_OP_RW, CSR_MCAUSE, 32'h55, 1'b0, 32'h0, 0, o);
    verify("bp_second", CSR_MCAUSE, 0, e, o);

    // Reset landing in the WRITE cycle of a CSRRW discards the op.
    @(negedge clk);
    req_valid = 1'b1; req_op = CSR_OP_RW; req_addr = CSR_MTVEC; req_src = 32'hDEADBEEC; req_src_zero = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    check("rstw.accept", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstw.csr_wen", 32'(csr_wen), 32'h0);
    check("rstw.csr_commit", 32'(csr_commit), 32'h0);
    check("rstw.req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstw.idle_ready", 32'(req_ready), 32'h1);
    check("rstw.rsp_valid", 32'(rsp_valid), 32'h0);
    model_op(CSR_OP_RS, CSR_MTVEC, 32'h0, 1'b1, 32'h0, e);
    run_op(CSR_OP_RS, CSR_MTVEC, 32'h0, 1'b1, 32'h0, 0, o);
    verify("rstw.mtvec_kept", CSR_MTVEC, 0, e, o);

    // Randomized ops against the model.
    ops  = '{CSR_OP_RW, CSR_OP_RS, CSR_OP_RC, CSR_OP_ECALL, CSR_OP_MRET};
    adrs = '{CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, 12'h7C0};
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [11:0] addr;
      logic [31:0] src, pc;
      logic        sz;
      int unsigned st;
      op   = ops[$urandom_range(0, 4)];
      addr = adrs[$urandom_range(0, 4)];
      sz   = 1'($urandom_range(0, 1));
      src  = sz ? 32'h0 : $urandom;
      pc   = $urandom & 32'hFFFF_FFFC;
      st   = $urandom_range(0, 2);
      model_op(op, addr, src, sz, pc, e);
      run_op(op, addr, src, sz, pc, st, o);
      verify($sformatf("rnd%0d", n), addr, st, e, o);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
# csr_access_ctrl

Sequencer between the decode/execute stage and the CSR unit. It accepts one CSR-class instruction at a time (CSRRW/CSRRS/CSRRC and their immediate forms, ECALL, MRET) over a valid/ready request port. It performs the read–modify–write against the CSR unit's port (addr/ctl/wen/wdata/pc/commit in, rdata/upc out), then returns the old CSR value and any PC redirect over a valid/ready response port to writeback/IFU.

## Interface
Parameters:
- XLEN, 32, data/PC width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  3  CSR_OP_RW/RS/RC/ECALL/MRET
- req_addr  in  12  CSR address
- req_src  in  XLEN  rs1 value or zero-extended uimm (decoder selects)
- req_src_zero  in  1  rs1==x0 / uimm==0
- req_pc  in  XLEN  instruction PC
- csr_addr  out  12  to CSR unit
- csr_ctl  out  3  CTL_NOP/CTL_CSRW/CTL_ECALL/CTL_MRET
- csr_wen  out  1  write enable
- csr_commit  out  1  write qualifier (CSR unit's ready input)
- csr_wdata  out  XLEN  new CSR value
- csr_pc  out  XLEN  PC for mepc on ECALL
- csr_rdata  in  XLEN  combinational read data
- csr_upc  in  XLEN  trap/return target
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  XLEN  old CSR value (rd writeback)
- rsp_redirect  out  1  PC redirect required
- rsp_npc  out  XLEN  redirect target
- rsp_illegal  out  1  unsupported CSR address

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture op/addr/src/src_zero/pc and go to READ.
- READ:
  - Drive csr_addr=captured addr, csr_ctl=CTL_NOP, csr_wen=0.
  - Register csr_rdata into old.
  - For ECALL/MRET, drive csr_ctl to the op so csr_upc is valid; register csr_upc.
  - Compute new value: RW: src; RS: old|src; RC: old&~src.
  - Go to WRITE.
- WRITE:
  - RW: ctl=CSRW, wen=commit=1, wdata=new.
  - RS/RC with src_zero=0: same as RW.
  - RS/RC with src_zero=1: no write.
  - ECALL: ctl=CTL_ECALL, wen=commit=1, csr_pc=captured pc.
  - MRET: no write.
  - Go to RESP.
- RESP:
  - rsp_valid=1; outputs held stable until rsp_ready.
  - On rsp_ready go to IDLE.
- Response fields:
  - RW/RS/RC: rsp_redirect=0, rsp_rdata=old.
  - ECALL/MRET: rsp_redirect=1, rsp_npc=registered upc, rsp_rdata=0.
- Legal addresses: 0x300, 0x305, 0x341, 0x342.
  - Any other address on RW/RS/RC: no write, rsp_illegal=1, rsp_rdata=0.
- mstatus reads as 0x1800 from the CSR unit; RS/RC on mstatus use that value.
- All arithmetic is XLEN-bit bitwise; no carries or sign extension.

## Timing
- Reset: state=IDLE. req_ready=0 while rst is high. All other outputs are 0 during reset and in idle.
- Request accepted at edge N.
  - READ during cycle N+1.
  - WRITE during cycle N+2.
  - rsp_valid high from cycle N+3.
- Next request is accepted no earlier than the cycle after the rsp handshake, giving at most one op per 4 cycles.
- csr_wen/csr_commit are high for exactly one cycle per writing op, and only in WRITE.
- The CSR write lands at the WRITE-cycle edge, so the response is never visible before the write has completed.
- req_valid is ignored outside IDLE.
- rst has priority in every state. If rst is high during WRITE, wen and commit are 0 that cycle. The next cycle is IDLE and the op is discarded.

## Structure
- Shared package/include holds:
  - CSR_OP_* encodings.
  - CTL_* encodings, which must match the CSR unit's control encodings.
  - CSR address constants (MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342).
  - FSM state encoding.
- One combinational sub-module, csr_wdata_calc: (op, old, src) → new value and write-needed flag.

## Test plan
- CSRRW 0x305, src=0x80000100, old 0 → WRITE cycle wen=1, ctl=CSRW, wdata=0x80000100; rsp_rdata=0, rsp_valid 3 cycles after accept.
- CSRRS 0x300, src=0x8 → wdata=0x1808, wen=1; rsp_rdata=0x1800.
- CSRRC 0x341, src_zero=1, mepc=0x1234 → wen stays 0 all op; rsp_rdata=0x1234.
- ECALL pc=0x80000040, mtvec=0x80000100 → WRITE ctl=ECALL, csr_pc=0x80000040; rsp_redirect=1, rsp_npc=0x80000100. A following CSRRS 0x342 with src_zero=1 returns 0xB.
- rsp_ready low 5 cycles with a new req_valid pending → response fields stable, req_ready=0, second request accepted only after the handshake. Illegal addr 0x7C0 → rsp_illegal=1, no wen.
- rst pulsed in WRITE cycle of a CSRRW → no wen that cycle; IDLE with req_ready=1 the cycle after rst drops.
